// File: rtl/usb_line_pkg.sv
`default_nettype none
// ============================================================================
// Module  : usb_line_pkg
// Brief   : Shared types and pad encodings for the USB transmit line stage.
// Revision: 1.0 - initial release
// ============================================================================
package usb_line_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_STUFF = 3'd2,
    ST_EOP1  = 3'd3,
    ST_EOP2  = 3'd4,
    ST_JBIT  = 3'd5
  } lineState_t;

  localparam int MAX_ONES     = 6;
  localparam int EOP_SE0_BITS = 2;

  // Pad pairs are packed as {dPlus, dMinus}.
  localparam logic [1:0] PAD_SE0  = 2'b00;
  localparam logic [1:0] PAD_J_LS = 2'b01;
  localparam logic [1:0] PAD_K_LS = 2'b10;
  localparam logic [1:0] PAD_J_FS = 2'b10;
  localparam logic [1:0] PAD_K_FS = 2'b01;

  function automatic logic [1:0] padLevel(input logic lowSpeed, input logic levelK);
    if (lowSpeed) return levelK ? PAD_K_LS : PAD_J_LS;
    return levelK ? PAD_K_FS : PAD_J_FS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_line_driver_if.sv
`default_nettype none
// ============================================================================
// Module  : usb_tx_line_driver_if
// Brief   : Upstream serial handshake and pad bundle of the USB line driver.
// Revision: 1.0 - initial release
// ============================================================================
interface usb_tx_line_driver_if;
  logic lineStrobe;
  logic srcStrobe;
  logic txBit;
  logic txOe;
  logic txEop;
  logic dPlus;
  logic dMinus;
  logic dOe;
  logic busy;
  logic abortPulse;

  modport master (
    output lineStrobe, txBit, txOe, txEop,
    input  srcStrobe, dPlus, dMinus, dOe, busy, abortPulse
  );

  modport slave (
    input  lineStrobe, txBit, txOe, txEop,
    output srcStrobe, dPlus, dMinus, dOe, busy, abortPulse
  );
endinterface
`default_nettype wire

// File: rtl/usb_bit_stuffer.sv
`default_nettype none
// ============================================================================
// Module  : usb_bit_stuffer
// Brief   : Consecutive-ones counter; flags the bit that completes a run of six.
// Revision: 1.0 - initial release
// ============================================================================
module usb_bit_stuffer
  import usb_line_pkg::*;
(
  input  logic useClk,
  input  logic reset,
  input  logic strobe,
  input  logic dataBit,
  input  logic clear,
  output logic stuffNow
);

  localparam logic [2:0] c_maxOnes = 3'(MAX_ONES);
  localparam logic [2:0] c_stuffAt = 3'(MAX_ONES - 1);

  logic [2:0] r_ones;

  always_ff @(posedge useClk) begin
    if (reset || clear) begin
      r_ones <= 3'd0;
    end else if (strobe) begin
      if (!dataBit)
        r_ones <= 3'd0;
      else if (r_ones != c_maxOnes)
        r_ones <= r_ones + 3'd1;
    end
  end

  // Asserted on the strobe whose 1 makes the run reach six.
  assign stuffNow = strobe && !clear && dataBit && (r_ones == c_stuffAt);

endmodule
`default_nettype wire

// File: rtl/usb_tx_line_driver.sv
`default_nettype none
// ============================================================================
// Module  : usb_tx_line_driver
// Brief   : Bit stuffing, NRZI, EOP generation and pad drive for USB transmit.
// Revision: 1.0 - initial release
// ============================================================================
module usb_tx_line_driver
  import usb_line_pkg::*;
#(
  parameter logic LOW_SPEED = 1'b1
) (
  input  logic                  useClk,
  input  logic                  reset,
  usb_tx_line_driver_if.slave   bus
);

  lineState_t r_state, w_nextState;
  logic       r_levelK, w_nextLevelK;
  logic [1:0] r_pad, w_nextPad;
  logic       r_dOe, w_nextOe;
  logic       r_busy, w_nextBusy;
  logic       r_abort, w_nextAbort;

  logic       w_encode;
  logic       w_clear;
  logic       w_stuffNow;

  // A data bit is encoded on the packet-start strobe or a normal DATA strobe.
  assign w_encode = bus.lineStrobe && bus.txOe &&
                    ((r_state == ST_IDLE) || ((r_state == ST_DATA) && !bus.txEop));
  assign w_clear  = bus.lineStrobe && !w_encode;

  usb_bit_stuffer u_stuffer (
    .useClk   (useClk),
    .reset    (reset),
    .strobe   (w_encode),
    .dataBit  (bus.txBit),
    .clear    (w_clear),
    .stuffNow (w_stuffNow)
  );

  always_comb begin
    w_nextState  = r_state;
    w_nextLevelK = r_levelK;
    w_nextPad    = r_pad;
    w_nextOe     = r_dOe;
    w_nextBusy   = r_busy;
    w_nextAbort  = 1'b0;
    if (bus.lineStrobe) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.txOe) begin
            w_nextLevelK = !bus.txBit;
            w_nextState  = w_stuffNow ? ST_STUFF : ST_DATA;
            w_nextPad    = padLevel(LOW_SPEED, !bus.txBit);
            w_nextOe     = 1'b1;
            w_nextBusy   = 1'b1;
          end
        end
        ST_DATA: begin
          if (bus.txEop || !bus.txOe) begin
            w_nextState = ST_EOP1;
            w_nextPad   = PAD_SE0;
            w_nextAbort = !bus.txEop;
          end else begin
            w_nextLevelK = bus.txBit ? r_levelK : !r_levelK;
            w_nextState  = w_stuffNow ? ST_STUFF : ST_DATA;
            w_nextPad    = padLevel(LOW_SPEED, bus.txBit ? r_levelK : !r_levelK);
          end
        end
        ST_STUFF: begin
          w_nextLevelK = !r_levelK;
          w_nextState  = ST_DATA;
          w_nextPad    = padLevel(LOW_SPEED, !r_levelK);
        end
        ST_EOP1: begin
          w_nextState = ST_EOP2;
          w_nextPad   = PAD_SE0;
        end
        ST_EOP2: begin
          w_nextState  = ST_JBIT;
          w_nextLevelK = 1'b0;
          w_nextPad    = padLevel(LOW_SPEED, 1'b0);
        end
        ST_JBIT: begin
          w_nextState  = ST_IDLE;
          w_nextLevelK = 1'b0;
          w_nextPad    = padLevel(LOW_SPEED, 1'b0);
          w_nextOe     = 1'b0;
          w_nextBusy   = 1'b0;
        end
        default: begin
          w_nextState  = ST_IDLE;
          w_nextLevelK = 1'b0;
          w_nextPad    = padLevel(LOW_SPEED, 1'b0);
          w_nextOe     = 1'b0;
          w_nextBusy   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge useClk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_levelK <= 1'b0;
      r_pad    <= padLevel(LOW_SPEED, 1'b0);
      r_dOe    <= 1'b0;
      r_busy   <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_levelK <= w_nextLevelK;
      r_pad    <= w_nextPad;
      r_dOe    <= w_nextOe;
      r_busy   <= w_nextBusy;
      r_abort  <= w_nextAbort;
    end
  end

  // Upstream only advances on strobes that carry its bit.
  assign bus.srcStrobe  = bus.lineStrobe && (r_state != ST_STUFF);
  assign bus.dPlus      = r_pad[1];
  assign bus.dMinus     = r_pad[0];
  assign bus.dOe        = r_dOe;
  assign bus.busy       = r_busy;
  assign bus.abortPulse = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_line_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_usb_tx_line_driver
// Brief   : Directed self-checking bench for the USB transmit line driver.
// Revision: 1.0 - initial release
// ============================================================================
module tb_usb_tx_line_driver;

  localparam logic [1:0] c_j   = 2'b01;  // low-speed {dPlus,dMinus}
  localparam logic [1:0] c_k   = 2'b10;
  localparam logic [1:0] c_se0 = 2'b00;

  logic useClk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  usb_tx_line_driver_if bus ();

  usb_tx_line_driver #(.LOW_SPEED(1'b1)) dut (
    .useClk (useClk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 useClk = ~useClk;

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bit time: two quiet cycles, then a strobe; pads are sampled after the edge.
  task automatic step(input string tag, input logic b, input logic oe, input logic eop,
                      input logic [1:0] expPad, input logic expOe, input logic expSrc);
    logic src;
    bus.txBit = b;
    bus.txOe  = oe;
    bus.txEop = eop;
    bus.lineStrobe = 1'b0;
    repeat (2) @(posedge useClk);
    #1;
    bus.lineStrobe = 1'b1;
    #1;
    src = bus.srcStrobe;
    @(posedge useClk);
    #1;
    bus.lineStrobe = 1'b0;
    checkVal({tag, ".src"}, 8'(src), 8'(expSrc));
    checkVal({tag, ".pad"}, 8'({bus.dPlus, bus.dMinus}), 8'(expPad));
    checkVal({tag, ".oe"},  8'(bus.dOe), 8'(expOe));
  endtask

  // EOP1 already entered: second SE0 (txOe rising ignored), J, then release.
  task automatic eopTail(input string tag);
    step({tag, ".se0b"}, 1'b0, 1'b1, 1'b0, c_se0, 1'b1, 1'b1);
    step({tag, ".jbit"}, 1'b0, 1'b1, 1'b0, c_j,   1'b1, 1'b1);
    checkVal({tag, ".busyJ"}, 8'(bus.busy), 8'd1);
    step({tag, ".rel"},  1'b0, 1'b0, 1'b0, c_j,   1'b0, 1'b1);
    checkVal({tag, ".busyRel"}, 8'(bus.busy), 8'd0);
  endtask

  logic [7:0] syncByte;
  logic [7:0] syncPads [8];

  initial begin
    reset = 1'b1;
    bus.lineStrobe = 1'b0;
    bus.txBit = 1'b0;
    bus.txOe  = 1'b0;
    bus.txEop = 1'b0;
    repeat (3) @(posedge useClk);
    #1;
    reset = 1'b0;

    checkVal("rst.oe",    8'(bus.dOe), 8'd0);
    checkVal("rst.pad",   8'({bus.dPlus, bus.dMinus}), 8'(c_j));
    checkVal("rst.busy",  8'(bus.busy), 8'd0);
    checkVal("rst.abort", 8'(bus.abortPulse), 8'd0);
    checkVal("rst.src",   8'(bus.srcStrobe), 8'd0);

    // Idle strobe without txOe keeps the line released.
    step("idle", 1'b0, 1'b0, 1'b0, c_j, 1'b0, 1'b1);

    // SYNC 0x80 LSB first: K J K J K J K K
    syncByte = 8'h80;
    syncPads = '{c_k, c_j, c_k, c_j, c_k, c_j, c_k, c_k};
    for (int i = 0; i < 8; i++)
      step($sformatf("sync%0d", i), syncByte[i], 1'b1, 1'b0, syncPads[i], 1'b1, 1'b1);
    checkVal("sync.busy", 8'(bus.busy), 8'd1);
    step("d0", 1'b0, 1'b1, 1'b0, c_j, 1'b1, 1'b1);
    step("eopA", 1'b0, 1'b1, 1'b1, c_se0, 1'b1, 1'b1);
    eopTail("eopA");

    // Eight 1s: stuff after the sixth, srcStrobe withheld in that slot.
    for (int i = 0; i < 6; i++)
      step($sformatf("ones%0d", i), 1'b1, 1'b1, 1'b0, c_j, 1'b1, 1'b1);
    step("ones.stuff", 1'b1, 1'b1, 1'b0, c_k, 1'b1, 1'b0);
    step("ones6", 1'b1, 1'b1, 1'b0, c_k, 1'b1, 1'b1);
    step("ones7", 1'b1, 1'b1, 1'b0, c_k, 1'b1, 1'b1);
    step("eopB", 1'b1, 1'b1, 1'b1, c_se0, 1'b1, 1'b1);
    eopTail("eopB");

    // 0 then six 1s, EOP requested in the stuff slot: stuff precedes SE0.
    step("s6.zero", 1'b0, 1'b1, 1'b0, c_k, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      step($sformatf("s6.one%0d", i), 1'b1, 1'b1, 1'b0, c_k, 1'b1, 1'b1);
    step("s6.stuff", 1'b0, 1'b1, 1'b1, c_j, 1'b1, 1'b0);
    step("eopC", 1'b0, 1'b1, 1'b1, c_se0, 1'b1, 1'b1);
    eopTail("eopC");

    // Reset mid-DATA after three 1s, then a fresh packet needs six new 1s.
    for (int i = 0; i < 3; i++)
      step($sformatf("pre%0d", i), 1'b1, 1'b1, 1'b0, c_j, 1'b1, 1'b1);
    reset = 1'b1;
    @(posedge useClk);
    #1;
    reset = 1'b0;
    checkVal("midrst.oe",   8'(bus.dOe), 8'd0);
    checkVal("midrst.pad",  8'({bus.dPlus, bus.dMinus}), 8'(c_j));
    checkVal("midrst.busy", 8'(bus.busy), 8'd0);
    for (int i = 0; i < 6; i++)
      step($sformatf("post%0d", i), 1'b1, 1'b1, 1'b0, c_j, 1'b1, 1'b1);
    step("post.stuff", 1'b1, 1'b1, 1'b0, c_k, 1'b1, 1'b0);
    step("post.zero", 1'b0, 1'b1, 1'b0, c_j, 1'b1, 1'b1);

    // txOe dropped without EOP: abort pulse for one cycle, then EOP tail.
    step("abort", 1'b0, 1'b0, 1'b0, c_se0, 1'b1, 1'b1);
    checkVal("abort.pulse", 8'(bus.abortPulse), 8'd1);
    @(posedge useClk);
    #1;
    checkVal("abort.end", 8'(bus.abortPulse), 8'd0);
    checkVal("abort.hold", 8'({bus.dPlus, bus.dMinus}), 8'(c_se0));
    eopTail("eopD");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
